// File: rtl/pegroup_driver.sv
// Tap sequencer for a group of Para_Deg MAC lanes: issues Kernel_Len taps per window,
// waits out the PE latency and returns the lane results. Define PEGROUP_DRIVER_RELU_EN
// to clamp negative lane results to zero on capture.
`timescale 1ns/1ps
module pegroup_driver #(
   parameter int unsigned Data_Width = 8,
   parameter int unsigned Para_Deg   = 3,
   parameter int unsigned Kernel_Len = 3,
   parameter int unsigned PE_Latency = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [Para_Deg*Data_Width-1:0]     in_data0,
   input  logic [Para_Deg*Data_Width-1:0]     in_data1,
   input  logic [Para_Deg*2*Data_Width-1:0]   in_bias,
   output logic [Para_Deg*Data_Width-1:0]     pe_data0,
   output logic [Para_Deg*Data_Width-1:0]     pe_data1,
   output logic                               pe_init,
   output logic [Para_Deg*2*Data_Width-1:0]   pe_old_output,
   input  logic [Para_Deg*2*Data_Width-1:0]   pe_result,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [Para_Deg*2*Data_Width-1:0]   out_data
);

   localparam int unsigned ACC_W  = 2 * Data_Width;
   localparam int unsigned DATA_W = Para_Deg * Data_Width;
   localparam int unsigned RES_W  = Para_Deg * ACC_W;
   localparam int unsigned CNT_W  = (Kernel_Len > 1) ? $clog2(Kernel_Len) : 1;
   localparam int unsigned DRN_W  = $clog2(PE_Latency + 1);

   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(Kernel_Len - 1);
   localparam logic [DRN_W-1:0] LAT_CNT  = DRN_W'(PE_Latency);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_e;

   state_e              state_q,    state_d;
   logic [CNT_W-1:0]    tap_cnt_q,  tap_cnt_d;
   logic [DRN_W-1:0]    drn_cnt_q,  drn_cnt_d;
   logic [DATA_W-1:0]   pe_data0_q, pe_data0_d;
   logic [DATA_W-1:0]   pe_data1_q, pe_data1_d;
   logic                pe_init_q,  pe_init_d;
   logic [RES_W-1:0]    pe_old_q,   pe_old_d;
   logic                out_valid_q, out_valid_d;
   logic [RES_W-1:0]    out_data_q, out_data_d;
   logic                in_ready_q, in_ready_d;

   logic                accept_c;
   logic [RES_W-1:0]    capture_c;
   logic [ACC_W-1:0]    lane_c;

   // Per-lane capture value; lanes are sliced independently so nothing carries across.
   always_comb begin
      capture_c = '0;
      lane_c    = '0;
      for (int l = 0; l < Para_Deg; l++) begin
         lane_c = pe_result[l*ACC_W +: ACC_W];
`ifdef PEGROUP_DRIVER_RELU_EN
         if (lane_c[ACC_W-1]) lane_c = '0;
`endif
         capture_c[l*ACC_W +: ACC_W] = lane_c;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         tap_cnt_q   <= '0;
         drn_cnt_q   <= '0;
         pe_data0_q  <= '0;
         pe_data1_q  <= '0;
         pe_init_q   <= 1'b0;
         pe_old_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tap_cnt_q   <= tap_cnt_d;
         drn_cnt_q   <= drn_cnt_d;
         pe_data0_q  <= pe_data0_d;
         pe_data1_q  <= pe_data1_d;
         pe_init_q   <= pe_init_d;
         pe_old_q    <= pe_old_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         in_ready_q  <= in_ready_d;
      end
   end

   // Next state; pe_data/pe_init fall to zero on any cycle without an accepted tap.
   always_comb begin
      state_d     = state_q;
      tap_cnt_d   = tap_cnt_q;
      drn_cnt_d   = drn_cnt_q;
      pe_data0_d  = '0;
      pe_data1_d  = '0;
      pe_init_d   = 1'b0;
      pe_old_d    = pe_old_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      accept_c    = in_valid && in_ready_q;

      case (state_q)
         IDLE, RUN: begin
            if (accept_c) begin
               pe_data0_d = in_data0;
               pe_data1_d = in_data1;
               if (tap_cnt_q == '0) begin
                  pe_init_d = 1'b1;
                  pe_old_d  = in_bias;
               end
               if (tap_cnt_q == LAST_TAP) begin
                  tap_cnt_d = '0;
                  drn_cnt_d = '0;
                  state_d   = DRAIN;
               end else begin
                  tap_cnt_d = tap_cnt_q + CNT_W'(1);
                  state_d   = RUN;
               end
            end
         end
         DRAIN: begin
            if (drn_cnt_q == LAT_CNT) begin
               out_data_d  = capture_c;
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end else begin
               drn_cnt_d = drn_cnt_q + DRN_W'(1);
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Registered ready tracks the state being entered, so it is low during reset.
      in_ready_d = (state_d == IDLE) || (state_d == RUN);
   end

   assign in_ready      = in_ready_q;
   assign pe_data0      = pe_data0_q;
   assign pe_data1      = pe_data1_q;
   assign pe_init       = pe_init_q;
   assign pe_old_output = pe_old_q;
   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;

endmodule

// File: tb/tb_pegroup_driver.sv
// Bench for pegroup_driver: a default instance (3 taps, latency 1) driven from a vector
// table, and a 1-tap / latency-3 instance for timing and clamp checks, each with a PE model.
`timescale 1ns/1ps
module tb_pegroup_driver;

   localparam int unsigned DW = 8;
   localparam int unsigned P  = 3;
   localparam int unsigned AW = 2 * DW;
   localparam int unsigned XW = P * DW;
   localparam int unsigned RW = P * AW;
   localparam int unsigned KA = 3;

   typedef struct {
      logic [XW-1:0] d0;
      logic [XW-1:0] d1;
      logic [RW-1:0] bias;
      int            gap;
      int            hold;
      logic [RW-1:0] exp;
   } vec_t;

   logic clk;
   logic reset;

   logic          a_in_valid, a_in_ready, a_pe_init, a_out_valid, a_out_ready;
   logic [XW-1:0] a_in_data0, a_in_data1, a_pe_data0, a_pe_data1;
   logic [RW-1:0] a_in_bias, a_pe_old_output, a_pe_result, a_out_data, a_acc;

   logic          b_in_valid, b_in_ready, b_pe_init, b_out_valid, b_out_ready;
   logic [XW-1:0] b_in_data0, b_in_data1, b_pe_data0, b_pe_data1;
   logic [RW-1:0] b_in_bias, b_pe_old_output, b_pe_result, b_out_data;
   logic [RW-1:0] b_acc, b_pipe1, b_pipe2;

   int n_checks = 0;
   int n_fail   = 0;
   logic [RW-1:0] exp_q [$];
   vec_t vecs [5];

   pegroup_driver #(.Data_Width(DW), .Para_Deg(P), .Kernel_Len(KA), .PE_Latency(1)) u_dut_a (
      .clk(clk), .reset(reset),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data0(a_in_data0), .in_data1(a_in_data1), .in_bias(a_in_bias),
      .pe_data0(a_pe_data0), .pe_data1(a_pe_data1), .pe_init(a_pe_init),
      .pe_old_output(a_pe_old_output), .pe_result(a_pe_result),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
   );

   pegroup_driver #(.Data_Width(DW), .Para_Deg(P), .Kernel_Len(1), .PE_Latency(3)) u_dut_b (
      .clk(clk), .reset(reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data0(b_in_data0), .in_data1(b_in_data1), .in_bias(b_in_bias),
      .pe_data0(b_pe_data0), .pe_data1(b_pe_data1), .pe_init(b_pe_init),
      .pe_old_output(b_pe_old_output), .pe_result(b_pe_result),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural PE group: lane = init ? old + d0*d1 : previous + d0*d1, modulo 2*DW bits.
   function automatic logic [RW-1:0] pe_step(input logic [RW-1:0] prev, input logic [RW-1:0] old,
                                            input logic [XW-1:0] d0, input logic [XW-1:0] d1,
                                            input logic init);
      logic [RW-1:0] r;
      logic [AW-1:0] base;
      r = '0;
      for (int l = 0; l < int'(P); l++) begin
         base = init ? old[l*AW +: AW] : prev[l*AW +: AW];
         r[l*AW +: AW] = base + AW'(d0[l*DW +: DW]) * AW'(d1[l*DW +: DW]);
      end
      return r;
   endfunction

   always @(posedge clk) begin
      a_acc   <= pe_step(a_acc, a_pe_old_output, a_pe_data0, a_pe_data1, a_pe_init);
      b_acc   <= pe_step(b_acc, b_pe_old_output, b_pe_data0, b_pe_data1, b_pe_init);
      b_pipe1 <= b_acc;
      b_pipe2 <= b_pipe1;
   end
   assign a_pe_result = a_acc;
   assign b_pe_result = b_pipe2;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Offer one tap at a falling edge, wait for its acceptance and check the issue.
   task automatic issue_tap_a(input logic [XW-1:0] d0, input logic [XW-1:0] d1,
                              input logic [RW-1:0] bias, input logic first);
      int t;
      a_in_valid = 1'b1;
      a_in_data0 = d0;
      a_in_data1 = d1;
      a_in_bias  = bias;
      t = 0;
      while (!a_in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!a_in_ready) fail_now("tap_accept_timeout");
      @(negedge clk);
      a_in_valid = 1'b0;
      check("issue_pe_data0", 64'(a_pe_data0), 64'(d0));
      check("issue_pe_data1", 64'(a_pe_data1), 64'(d1));
      check("issue_pe_init", 64'(a_pe_init), 64'(first));
      if (first) check("issue_pe_old_output", 64'(a_pe_old_output), 64'(bias));
   endtask

   task automatic run_window_a(input vec_t v);
      int t;
      logic [RW-1:0] held;
      exp_q.push_back(v.exp);
      a_out_ready = (v.hold == 0);
      for (int k = 0; k < int'(KA); k++) begin
         issue_tap_a(v.d0, v.d1, v.bias, k == 0);
         if (k == 0) begin
            for (int g = 0; g < v.gap; g++) begin
               @(negedge clk);
               check("gap_pe_data0", 64'(a_pe_data0), 64'(0));
               check("gap_pe_init", 64'(a_pe_init), 64'(0));
            end
         end
      end
      t = 0;
      while (!a_out_valid && t < 30) begin
         @(negedge clk);
         t++;
      end
      if (!a_out_valid) fail_now("out_valid_timeout");
      held = a_out_data;
      if (v.hold > 0) begin
         a_in_valid = 1'b1;
         a_in_data0 = {P{8'h55}};
         a_in_data1 = {P{8'h55}};
         for (int h = 0; h < v.hold; h++) begin
            check("hold_out_data", 64'(a_out_data), 64'(held));
            check("hold_out_valid", 64'(a_out_valid), 64'(1));
            check("hold_in_ready", 64'(a_in_ready), 64'(0));
            @(negedge clk);
            check("hold_tap_rejected", 64'(a_pe_data0), 64'(0));
         end
         a_in_valid = 1'b0;
      end
      a_out_ready = 1'b1;
      check("out_valid_at_handshake", 64'(a_out_valid), 64'(1));
      check("out_data", 64'(a_out_data), 64'(exp_q.pop_front()));
      @(negedge clk);
      check("out_valid_one_cycle", 64'(a_out_valid), 64'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      vec_t rv;
      logic [RW-1:0] b_exp;

      vecs[0] = '{d0: {3{8'd2}}, d1: {3{8'd100}}, bias: {3{16'd1000}}, gap: 0, hold: 0,
                  exp: {3{16'd1600}}};
      vecs[1] = '{d0: {3{8'd2}}, d1: {3{8'd100}}, bias: {3{16'd1000}}, gap: 2, hold: 0,
                  exp: {3{16'd1600}}};
      vecs[2] = '{d0: {3{8'd2}}, d1: {3{8'd100}}, bias: {3{16'd1000}}, gap: 0, hold: 5,
                  exp: {3{16'd1600}}};
      vecs[3] = '{d0: {8'd255, 8'd16, 8'd3}, d1: {8'd255, 8'd16, 8'd7},
                  bias: {16'd1000, 16'd100, 16'hFFF0}, gap: 0, hold: 0,
                  exp: {16'd65003, 16'd868, 16'd47}};
      vecs[4] = '{d0: {3{8'd0}}, d1: {3{8'd9}}, bias: {16'd5, 16'd6, 16'd7}, gap: 1, hold: 2,
                  exp: {16'd5, 16'd6, 16'd7}};
      rv      = '{d0: {3{8'd1}}, d1: {3{8'd1}}, bias: '0, gap: 0, hold: 0, exp: {3{16'd3}}};

      reset       = 1'b0;
      a_in_valid  = 1'b0;
      a_in_data0  = '0;
      a_in_data1  = '0;
      a_in_bias   = '0;
      a_out_ready = 1'b0;
      b_in_valid  = 1'b0;
      b_in_data0  = '0;
      b_in_data1  = '0;
      b_in_bias   = '0;
      b_out_ready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(a_in_ready), 64'(0));
      check("rst_out_valid", 64'(a_out_valid), 64'(0));
      check("rst_pe_init", 64'(a_pe_init), 64'(0));
      check("rst_pe_data0", 64'(a_pe_data0), 64'(0));
      check("rst_out_data", 64'(a_out_data), 64'(0));
      check("rst_b_in_ready", 64'(b_in_ready), 64'(0));
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_window_a(vecs[i]);

      // Partial window interrupted by reset, then a fresh window.
      a_out_ready = 1'b1;
      issue_tap_a({3{8'd2}}, {3{8'd100}}, {3{16'd1000}}, 1'b1);
      issue_tap_a({3{8'd2}}, {3{8'd100}}, {3{16'd1000}}, 1'b0);
      reset = 1'b0;
      #1;
      check("midrst_in_ready", 64'(a_in_ready), 64'(0));
      check("midrst_pe_init", 64'(a_pe_init), 64'(0));
      check("midrst_pe_data0", 64'(a_pe_data0), 64'(0));
      check("midrst_pe_data1", 64'(a_pe_data1), 64'(0));
      check("midrst_pe_old_output", 64'(a_pe_old_output), 64'(0));
      check("midrst_out_valid", 64'(a_out_valid), 64'(0));
      check("midrst_out_data", 64'(a_out_data), 64'(0));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      run_window_a(rv);

      // Single-tap instance with PE latency 3.
`ifdef PEGROUP_DRIVER_RELU_EN
      b_exp = {16'h0000, 16'h0016, 16'h0000};
`else
      b_exp = {16'h8000, 16'h0016, 16'hFFFF};
`endif
      exp_q.push_back(b_exp);
      b_in_valid = 1'b1;
      b_in_data0 = {8'h10, 8'd3, 8'hFF};
      b_in_data1 = {8'h10, 8'd4, 8'h01};
      b_in_bias  = {16'h7F00, 16'd10, 16'hFF00};
      t = 0;
      while (!b_in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!b_in_ready) fail_now("b_tap_accept_timeout");
      @(posedge clk);
      @(negedge clk);
      b_in_valid = 1'b0;
      check("b_pe_init", 64'(b_pe_init), 64'(1));
      check("b_pe_old_output", 64'(b_pe_old_output), 64'({16'h7F00, 16'd10, 16'hFF00}));
      t = 0;
      while (!b_out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("b_out_valid_latency", 64'(t), 64'(4));
      check("b_out_data", 64'(b_out_data), 64'(exp_q.pop_front()));
      @(negedge clk);
      check("b_out_valid_one_cycle", 64'(b_out_valid), 64'(0));
      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pegroup_driver.md
PEGROUP_DRIVER -- requirements
Module: pegroup_driver

Interface
REQ-001 SHALL have parameter Data_Width, default 8, meaning the operand width per lane.
REQ-002 SHALL have parameter Para_Deg, default 3, meaning the number of parallel PE lanes.
REQ-003 SHALL have parameter Kernel_Len, default 3, meaning the number of taps per output window (at least 1).
REQ-004 SHALL have parameter PE_Latency, default 1, meaning the number of cycles from a tap issue until pe_result reflects that tap (at least 1).
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data0 and in_data1 (inputs, Para_Deg*Data_Width), and in_bias (input, Para_Deg*2*Data_Width); together these form the tap-input handshake.
REQ-008 SHALL have ports pe_data0 and pe_data1 (outputs, Para_Deg*Data_Width), pe_init (output, 1) and pe_old_output (output, Para_Deg*2*Data_Width); these drive the PE group.
REQ-009 SHALL have port pe_result, input, Para_Deg*2*Data_Width, the PE group's accumulated result.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, Para_Deg*2*Data_Width); these form the result handshake.

Function
REQ-011 SHALL assume this PE contract: PE_Latency cycles after issue, lane result = pe_init ? pe_old_output + d0*d1 : previous result + d0*d1.
REQ-012 SHALL implement FSM states IDLE, RUN, DRAIN and HOLD.
REQ-013 SHALL drive in_ready = 1 in IDLE and RUN only.
REQ-014 SHALL accept a tap when in_valid && in_ready, then register in_data0/in_data1 onto pe_data0/pe_data1 on the next edge (1-cycle issue latency).
REQ-015 SHALL use a tap counter of 0..Kernel_Len-1: on an accepted tap with counter 0, pe_init=1 and pe_old_output<=in_bias; otherwise pe_init=0.
REQ-016 SHALL, on any cycle with no accepted tap, drive pe_data0=0, pe_data1=0 and pe_init=0, so that gaps (in_valid low) add zero to the accumulation.
REQ-017 SHALL transition IDLE->RUN on an accepted tap when Kernel_Len>1; the accepted tap that makes counter == Kernel_Len-1 SHALL go to DRAIN and wrap the counter to 0.
REQ-018 SHALL, in DRAIN, count PE_Latency cycles after the last issue, then capture pe_result into out_data, set out_valid=1 and enter HOLD.
REQ-019 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, in HOLD, on out_ready=1 clear out_valid and return to IDLE; a new tap is accepted no earlier than the following cycle.
REQ-021 SHALL, when Kernel_Len=1, send the single accepted tap directly from IDLE to DRAIN.
REQ-022 SHALL treat out_ready as ignored while out_valid=0; an out_ready asserted early SHALL have no effect.
REQ-023 SHALL keep lanes independent, with no carry between lanes, and capture full 2*Data_Width lane results without truncation.

Reset
REQ-024 SHALL, while reset=0, immediately force: state=IDLE, tap counter=0, pe_data0=0, pe_data1=0, pe_init=0, pe_old_output=0, out_valid=0, out_data=0 and in_ready=0.
REQ-025 SHALL discard any partial window on reset assertion mid-operation; after release, the first accepted tap starts a new window with pe_init=1.

Configuration
REQ-026 SHALL, with macro PEGROUP_DRIVER_RELU_EN defined, clamp each captured lane to 0 when its MSB is 1 (signed negative) before loading out_data; without the macro, lanes SHALL be captured unmodified.

Verification
REQ-027 SHALL cover this scenario: all lanes d0=2, d1=100, bias=1000, three back-to-back taps, out_ready=1 -> every lane of out_data=1600, and out_valid is high for exactly 1 cycle.
REQ-028 SHALL cover this scenario: same data with in_valid low for 2 cycles between tap 1 and tap 2 -> result still 1600, with pe_data0=0 and pe_init=0 during the gap.
REQ-029 SHALL cover this scenario: out_ready held 0 for 5 cycles after out_valid -> out_data is stable at 1600, in_ready=0 throughout, and a tap offered then is not accepted.
REQ-030 SHALL cover this scenario: reset pulsed low after tap 2, then a fresh 3-tap window with d0=1, d1=1, bias=0 -> lanes=3, with pe_init=1 on the first post-reset issue.
REQ-031 SHALL cover this scenario: with the macro, lane 0 d0=0xFF, d1=0x01, bias=0xFF00, Kernel_Len=1 -> lane 0 value 0xFFFF (negative) outputs 0; without the macro, it outputs 0xFFFF.
REQ-032 SHALL cover this scenario: Kernel_Len=1 with PE_Latency=3 -> out_valid rises exactly 4 cycles after the accepted tap edge.
